// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory load controller.
// Holds the controller phase encoding and the memory geometry defaults.
package imem_pkg;

    localparam int DEPTH_DEF  = 64;
    localparam int ADDR_W_DEF = 6;
    localparam int DATA_W_DEF = 32;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2
    } state_t;

endpackage

// File: rtl/imem_load_ctrl.sv
// Owns the instruction memory port: zero-fill, boot-stream load, then CPU fetch.
// The CPU is held in reset until a program is resident.
//
// state | meaning
// CLEAR | sweep every word to zero, one write per cycle
// LOAD  | accept boot words into consecutive addresses
// RUN   | program resident, serve CPU fetches
module imem_load_ctrl
    import imem_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_ld_valid,
    input  logic [DATA_W-1:0] i_ld_data,
    input  logic              i_ld_last,
    output logic              o_ld_ready,
    input  logic              i_reload,
    input  logic              i_fetch_req,
    input  logic [31:0]       i_fetch_addr,
    output logic              o_fetch_valid,
    output logic [DATA_W-1:0] o_fetch_rdata,
    output logic              o_fetch_err,
    output logic              o_cpu_hold,
    output logic              o_load_done,
    output logic [ADDR_W:0]   o_load_count,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    localparam logic [ADDR_W-1:0] LAST_PTR   = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   LAST_COUNT = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [31:0]       BYTE_LIMIT = 32'(DEPTH * 4);

    state_t            r_state;
    logic [ADDR_W-1:0] r_clr_ptr;
    logic [ADDR_W:0]   r_load_count;
    logic              r_fetch_valid;
    logic              r_fetch_err;

    logic w_ld_accept;
    logic w_fetch_fire;
    logic w_fetch_bad;

    // Decode is suppressed during reset so the memory port stays quiet.
    assign w_ld_accept  = !i_reset && (r_state == LOAD) && i_ld_valid;
    assign w_fetch_fire = !i_reset && (r_state == RUN) && i_fetch_req && !i_reload;
    assign w_fetch_bad  = (i_fetch_addr[1:0] != 2'b00) || (i_fetch_addr >= BYTE_LIMIT);

    assign o_ld_ready   = !i_reset && (r_state == LOAD);
    assign o_cpu_hold   = (r_state != RUN);
    assign o_load_done  = (r_state == RUN);
    assign o_load_count = r_load_count;

    always_comb begin
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        if (!i_reset && r_state == CLEAR) begin
            o_mem_we   = 1'b1;
            o_mem_addr = r_clr_ptr;
        end else if (w_ld_accept) begin
            o_mem_we    = 1'b1;
            o_mem_addr  = r_load_count[ADDR_W-1:0];
            o_mem_wdata = i_ld_data;
        end else if (w_fetch_fire) begin
            o_mem_addr = i_fetch_addr[ADDR_W+1:2];
        end
    end

    // Read data arrives from the array in the response cycle, so it is muxed, not registered.
    assign o_fetch_valid = r_fetch_valid;
    assign o_fetch_err   = r_fetch_err;
    assign o_fetch_rdata = !r_fetch_valid ? '0 :
                           r_fetch_err    ? DATA_W'(NOP_INSTR) : i_mem_rdata;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= CLEAR;
            r_clr_ptr     <= '0;
            r_load_count  <= '0;
            r_fetch_valid <= 1'b0;
            r_fetch_err   <= 1'b0;
        end else begin
            r_fetch_valid <= w_fetch_fire;
            r_fetch_err   <= w_fetch_fire && w_fetch_bad;
            case (r_state)
                CLEAR: begin
                    r_clr_ptr <= r_clr_ptr + 1'b1;
                    if (r_clr_ptr == LAST_PTR) begin
                        r_state      <= LOAD;
                        r_load_count <= '0;
                    end
                end
                LOAD: begin
                    if (w_ld_accept) begin
                        r_load_count <= r_load_count + 1'b1;
                        if (i_ld_last || r_load_count == LAST_COUNT) begin
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (i_reload) begin
                        r_state      <= CLEAR;
                        r_clr_ptr    <= '0;
                        r_load_count <= '0;
                    end
                end
                default: begin
                    r_state   <= CLEAR;
                    r_clr_ptr <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Self-checking bench for imem_load_ctrl with a synchronous-read memory model
// and a fetch-response scoreboard.
module tb_imem_load_ctrl;
    import imem_pkg::*;

    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              ld_valid = 1'b0;
    logic [DATA_W-1:0] ld_data = '0;
    logic              ld_last = 1'b0;
    logic              ld_ready;
    logic              reload = 1'b0;
    logic              fetch_req = 1'b0;
    logic [31:0]       fetch_addr = '0;
    logic              fetch_valid;
    logic [DATA_W-1:0] fetch_rdata;
    logic              fetch_err;
    logic              cpu_hold;
    logic              load_done;
    logic [ADDR_W:0]   load_count;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic [DATA_W-1:0] mem_arr [DEPTH];
    logic [DATA_W-1:0] model   [DEPTH];
    logic [32:0]       sb [$];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem_arr[mem_addr] <= mem_wdata;
        mem_rdata <= mem_arr[mem_addr];
    end

    imem_load_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_ld_valid(ld_valid), .i_ld_data(ld_data), .i_ld_last(ld_last), .o_ld_ready(ld_ready),
        .i_reload(reload), .i_fetch_req(fetch_req), .i_fetch_addr(fetch_addr),
        .o_fetch_valid(fetch_valid), .o_fetch_rdata(fetch_rdata), .o_fetch_err(fetch_err),
        .o_cpu_hold(cpu_hold), .o_load_done(load_done), .o_load_count(load_count),
        .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .i_mem_rdata(mem_rdata)
    );

    // Advance one clock and retire any fetch response against the scoreboard.
    task automatic tick();
        logic [32:0] exp;
        @(posedge clk);
        #1;
        if (fetch_valid === 1'b1) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL fetch_unexpected: got valid err=%0b data=%h, required no response", fetch_err, fetch_rdata);
            end else begin
                exp = sb.pop_front();
                if ({fetch_err, fetch_rdata} !== exp) begin
                    n_bad++;
                    $display("FAIL fetch_resp: got err=%0b data=%h, required err=%0b data=%h",
                             fetch_err, fetch_rdata, exp[32], exp[31:0]);
                end
            end
        end
    endtask

    task automatic push_fetch(input logic [31:0] a);
        logic bad;
        bad = (a[1:0] != 2'b00) || (a >= 32'(DEPTH * 4));
        fetch_req  = 1'b1;
        fetch_addr = a;
        if (bad) sb.push_back({1'b1, NOP_INSTR});
        else     sb.push_back({1'b0, model[a[7:2]]});
    endtask

    task automatic check_drained(input string name);
        tick();
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL %s_drain: got %0d pending responses, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic check_sweep(input string name);
        int errs = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (mem_we !== 1'b1 || mem_addr !== ADDR_W'(i) || mem_wdata !== '0 || ld_ready !== 1'b0) begin
                errs++;
                if (errs < 4)
                    $display("FAIL %s_clear[%0d]: got we=%0b addr=%0d wdata=%h rdy=%0b, required we=1 addr=%0d wdata=0 rdy=0",
                             name, i, mem_we, mem_addr, mem_wdata, ld_ready, i);
            end
            tick();
        end
        n_cmp++;
        if (errs != 0) n_bad++;
        n_cmp++;
        if (ld_ready !== 1'b1 || cpu_hold !== 1'b1 || load_done !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_to_load: got rdy=%0b hold=%0b done=%0b, required 1 1 0", name, ld_ready, cpu_hold, load_done);
        end
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        n_cmp++;
        if (mem_we !== 1'b0 || cpu_hold !== 1'b1 || load_done !== 1'b0 || load_count !== '0 ||
            ld_ready !== 1'b0 || fetch_valid !== 1'b0 || fetch_err !== 1'b0 || fetch_rdata !== '0) begin
            n_bad++;
            $display("FAIL reset_vals: got we=%0b hold=%0b done=%0b cnt=%0d rdy=%0b fv=%0b fe=%0b fd=%h",
                     mem_we, cpu_hold, load_done, load_count, ld_ready, fetch_valid, fetch_err, fetch_rdata);
        end
        rst = 1'b0;
        #1;
        check_sweep("reset");
    endtask

    task automatic test_load3();
        logic [31:0] words [3];
        words[0] = 32'h0050_0093; words[1] = 32'h0010_0113; words[2] = 32'h0020_81B3;
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1'b0;
            #1;
            n_cmp++;
            if (mem_we !== 1'b0 || ld_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL load_gap: got we=%0b rdy=%0b, required we=0 rdy=1", mem_we, ld_ready);
            end
            tick();
            ld_valid = 1'b1; ld_data = words[i]; ld_last = (i == 2);
            #1;
            n_cmp++;
            if (mem_we !== 1'b1 || mem_addr !== ADDR_W'(i) || mem_wdata !== words[i]) begin
                n_bad++;
                $display("FAIL load_write[%0d]: got we=%0b addr=%0d data=%h, required 1 %0d %h",
                         i, mem_we, mem_addr, mem_wdata, i, words[i]);
            end
            model[i] = words[i];
            tick();
            n_cmp++;
            if (i < 2 && (cpu_hold !== 1'b1 || load_count !== (ADDR_W+1)'(i + 1))) begin
                n_bad++;
                $display("FAIL load_mid[%0d]: got hold=%0b cnt=%0d, required 1 %0d", i, cpu_hold, load_count, i + 1);
            end
        end
        ld_valid = 1'b0; ld_last = 1'b0;
        n_cmp++;
        if (cpu_hold !== 1'b0 || load_done !== 1'b1 || load_count !== 7'd3 || ld_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL load_done: got hold=%0b done=%0b cnt=%0d rdy=%0b, required 0 1 3 0",
                     cpu_hold, load_done, load_count, ld_ready);
        end
    endtask

    task automatic test_fetch();
        logic [31:0] addrs [4];
        addrs[0] = 32'h0; addrs[1] = 32'h4; addrs[2] = 32'h8; addrs[3] = 32'hC;
        for (int i = 0; i < 4; i++) begin
            push_fetch(addrs[i]);
            #1;
            n_cmp++;
            if (mem_addr !== addrs[i][7:2] || mem_we !== 1'b0) begin
                n_bad++;
                $display("FAIL fetch_addr: got addr=%0d we=%0b, required %0d 0", mem_addr, mem_we, addrs[i][7:2]);
            end
            tick();
            fetch_req = 1'b0;
            n_cmp++;
            if (fetch_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL fetch_latency: got valid=%0b, required 1", fetch_valid);
            end
            tick();
        end
        check_drained("fetch");
    endtask

    task automatic test_back_to_back();
        push_fetch(32'h4);
        tick();
        push_fetch(32'h8);
        tick();
        fetch_req = 1'b0;
        tick();
        n_cmp++;
        if (fetch_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_pulse: got valid=%0b, required 0", fetch_valid);
        end
        check_drained("b2b");
    endtask

    task automatic test_bad_addr();
        logic [31:0] addrs [4];
        addrs[0] = 32'h6; addrs[1] = 32'h100; addrs[2] = 32'hFC; addrs[3] = 32'h8000_0000;
        for (int i = 0; i < 4; i++) begin
            push_fetch(addrs[i]);
            tick();
        end
        fetch_req = 1'b0;
        tick();
        check_drained("bad");
    endtask

    task automatic test_reload();
        reload = 1'b1;
        fetch_req = 1'b1; fetch_addr = 32'h0;
        tick();
        reload = 1'b0; fetch_req = 1'b0;
        n_cmp++;
        if (fetch_valid !== 1'b0 || cpu_hold !== 1'b1 || load_done !== 1'b0 || load_count !== '0) begin
            n_bad++;
            $display("FAIL reload: got fv=%0b hold=%0b done=%0b cnt=%0d, required 0 1 0 0",
                     fetch_valid, cpu_hold, load_done, load_count);
        end
        check_sweep("reload");
    endtask

    task automatic test_overflow();
        int acc = 0;
        for (int i = 0; i < 70; i++) begin
            ld_valid = 1'b1; ld_data = 32'hA000_0000 + 32'(i); ld_last = 1'b0;
            #1;
            if (ld_ready === 1'b1) begin
                model[acc] = ld_data;
                acc++;
            end
            tick();
        end
        ld_valid = 1'b0;
        n_cmp++;
        if (acc != DEPTH || load_count !== 7'd64 || ld_ready !== 1'b0 || cpu_hold !== 1'b0) begin
            n_bad++;
            $display("FAIL overflow: got acc=%0d cnt=%0d rdy=%0b hold=%0b, required 64 64 0 0",
                     acc, load_count, ld_ready, cpu_hold);
        end
        push_fetch(32'h0);  tick();
        push_fetch(32'hFC); tick();
        push_fetch(32'h80); tick();
        fetch_req = 1'b0;
        tick();
        check_drained("overflow");
    endtask

    task automatic test_reset_mid();
        fetch_req = 1'b1; fetch_addr = 32'h4;
        rst = 1'b1;
        tick();
        fetch_req = 1'b0;
        n_cmp++;
        if (fetch_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_fetch: got valid=%0b, required 0", fetch_valid);
        end
        rst = 1'b0;
        #1;
        check_sweep("rst1");
        for (int i = 0; i < 2; i++) begin
            ld_valid = 1'b1; ld_data = 32'h1111_0000 + 32'(i);
            tick();
        end
        ld_valid = 1'b0;
        n_cmp++;
        if (load_count !== 7'd2) begin
            n_bad++;
            $display("FAIL rst_preload: got cnt=%0d, required 2", load_count);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n_cmp++;
        if (load_count !== '0 || mem_we !== 1'b1 || mem_addr !== '0 || ld_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_midload: got cnt=%0d we=%0b addr=%0d rdy=%0b, required 0 1 0 0",
                     load_count, mem_we, mem_addr, ld_ready);
        end
        check_sweep("rst2");
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        test_reset();
        test_load3();
        test_fetch();
        test_back_to_back();
        test_bad_addr();
        test_reload();
        test_overflow();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/imem_load_ctrl.md
# imem_load_ctrl

Controller that owns the single port of the 64-word instruction memory and sequences it through three phases after reset: zero-fill, program load from a boot stream, then CPU instruction fetch. It holds the CPU in reset until a program is resident, serves fetches with one-cycle latency, and flags misaligned or out-of-range fetch addresses. It sits between the boot loader (UART/JTAG stream), the instruction memory array and the CPU fetch stage.

## Interface
- DEPTH, 64: instruction memory words.
- ADDR_W, 6: word-address width, clog2(DEPTH).
- DATA_W, 32: instruction width.
- CLK  in  1  single clock; all logic on posedge.
- RESET  in  1  synchronous, active-high reset.
- ld_valid  in  1  boot word valid.
- ld_data  in  DATA_W  boot word.
- ld_last  in  1  final word of program; qualified by ld_valid.
- ld_ready  out  1  controller accepts a boot word this cycle.
- reload  in  1  pulse in RUN: restart at CLEAR.
- fetch_req  in  1  CPU fetch request.
- fetch_addr  in  32  CPU byte address.
- fetch_valid  out  1  fetch_rdata valid.
- fetch_rdata  out  DATA_W  fetched instruction.
- fetch_err  out  1  fetch was misaligned or out of range.
- cpu_hold  out  1  hold CPU in reset.
- load_done  out  1  program resident (state RUN).
- load_count  out  ADDR_W+1  words written by the last load.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory word address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_addr (synchronous read).

## Operation
- States: CLEAR -> LOAD -> RUN; RUN -> CLEAR on reload.
- CLEAR: clr_ptr counts 0..DEPTH-1; mem_we=1, mem_addr=clr_ptr, mem_wdata=0 every cycle. After writing DEPTH-1, go to LOAD with ld_ptr=0.
- LOAD: ld_ready=1. On ld_valid: mem_we=1, mem_addr=ld_ptr, mem_wdata=ld_data, ld_ptr++. Go to RUN after accepting a word with ld_last=1, or after accepting word DEPTH-1 (overflow cap; later words are not accepted). load_count=number of accepted words (1..DEPTH).
- RUN: cpu_hold=0, load_done=1, mem_we=0. On fetch_req: mem_addr=fetch_addr[ADDR_W+1:2]. The request is bad if fetch_addr[1:0]!=0 or fetch_addr>=DEPTH*4.
- Fetch response, next cycle: good request -> fetch_valid=1, fetch_rdata=mem_rdata, fetch_err=0. Bad request -> fetch_valid=1, fetch_err=1, fetch_rdata=NOP (32'h00000013).
- reload and fetch_req in the same cycle: reload wins, the fetch is dropped, and no fetch_valid follows.
- fetch_req outside RUN and ld_valid outside LOAD are ignored.
- fetch_valid and fetch_err are single-cycle pulses per request.
- mem_addr=0 and mem_wdata=0 whenever not otherwise driven.

## Timing
- Reset values: state=CLEAR, clr_ptr=0, ld_ptr=0, ld_ready=0, cpu_hold=1, load_done=0, load_count=0, fetch_valid=0, fetch_err=0, fetch_rdata=0, mem_we=0.
- RESET wins over everything, including mid-CLEAR, mid-LOAD and an in-flight fetch. Restart is at clear address 0, and no fetch_valid is issued for a dropped request.
- First clear write occurs in the first cycle after RESET deasserts. CLEAR lasts exactly DEPTH cycles.
- ld_ready and mem_we/mem_addr/mem_wdata decode combinationally from state and inputs. ld_ready=1 in every LOAD cycle. Acceptance occurs on ld_valid & ld_ready.
- cpu_hold falls, and load_done rises, in the cycle after the final accepted word.
- Fetch latency is 1 cycle. Back-to-back requests are allowed at full throughput.
- load_count updates with each accepted word and holds in RUN. Entering CLEAR clears it to 0.

## Structure
- Shared package imem_pkg: state enum {CLEAR, LOAD, RUN}, NOP_INSTR=32'h00000013, and the default DEPTH/ADDR_W.
- No sub-module: one FSM plus pointers. The memory array is external.
- The testbench pairs the block with a simple synchronous-read DEPTH x DATA_W array model.

## Test plan
- Reset, idle loader: mem_we=1 for 64 cycles at addresses 0..63 with data 0, then ld_ready=1 and cpu_hold=1.
- Load 3 words (0x00500093, 0x00100113, 0x002081B3, last on the 3rd) with ld_valid gaps: load_count=3 and cpu_hold=0 the cycle after. Fetches at 0x0, 0x4, 0x8 return those words and 0xC returns 0, each fetch_valid one cycle later.
- Back-to-back fetches at 0x4 then 0x8 on consecutive cycles: fetch_valid high 2 cycles with the correct data in order.
- Fetches at 0x6 and 0x100: fetch_err=1 and fetch_rdata=0x00000013.
- Stream 70 words with no ld_last: exactly 64 accepted, load_count=64, ld_ready low afterwards.
- reload with a simultaneous fetch_req in RUN: no fetch_valid, cpu_hold=1 and the CLEAR sweep restarts. RESET asserted mid-LOAD restarts CLEAR from address 0 with load_count=0.
